// File: rtl/prewish_mask_sequencer_if.sv
// Mask-sequencer bus: run control, config port and the strobe/data link
// into the blinky. The sequencer sits on the slave side; the stimulus or
// parent logic sits on the master side.
interface prewish_mask_sequencer_if #(
  parameter int AW = 2
);
  logic          EN_I;
  logic          CFG_WE_I;
  logic          CFG_LAST_WE_I;
  logic [AW-1:0] CFG_ADR_I;
  logic [7:0]    CFG_DAT_I;
  logic          ACK_I;
  logic          STB_O;
  logic [7:0]    DAT_O;
  logic [AW-1:0] SLOT_O;
  logic          BUSY_O;
  logic          TIMEOUT_O;

  modport slave (
    input  EN_I, CFG_WE_I, CFG_LAST_WE_I, CFG_ADR_I, CFG_DAT_I, ACK_I,
    output STB_O, DAT_O, SLOT_O, BUSY_O, TIMEOUT_O
  );

  modport master (
    output EN_I, CFG_WE_I, CFG_LAST_WE_I, CFG_ADR_I, CFG_DAT_I, ACK_I,
    input  STB_O, DAT_O, SLOT_O, BUSY_O, TIMEOUT_O
  );
endinterface

// File: rtl/prewish_mask_sequencer.sv
// Plays a table of 8-bit blink masks into the blinky. Each slot presents its
// mask, emits a single strobe, then waits for the blinky's acknowledge or a
// dwell timeout before moving to the next slot (wrapping after LAST).
module prewish_mask_sequencer #(
  parameter int                 NUM_SLOTS = 4,
  parameter int                 DWELL_W   = 16,
  parameter logic [DWELL_W-1:0] DWELL     = 16'd50000
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  prewish_mask_sequencer_if.slave  bus
);

  localparam int                 AW       = $clog2(NUM_SLOTS);
  localparam logic [AW-1:0]      LAST_RST = AW'(NUM_SLOTS - 1);
  localparam logic [DWELL_W-1:0] DWELL_M1 = DWELL - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_WAIT,
    S_ADVANCE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         mask_q [NUM_SLOTS];
  logic [7:0]         mask_d [NUM_SLOTS];
  logic [AW-1:0]      last_q, last_d;
  logic [AW-1:0]      slot_q, slot_d;         // pointer to the slot in play
  logic [AW-1:0]      slot_out_q, slot_out_d; // slot shown on SLOT_O
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [7:0]         dat_q, dat_d;
  logic               stb_q, stb_d;
  logic               busy_q, busy_d;
  logic               to_q, to_d;

  // Next-state, config writes and registered-output values for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned; that is what keeps this block free of latches.
    state_d    = state_q;
    mask_d     = mask_q;
    last_d     = last_q;
    slot_d     = slot_q;
    slot_out_d = slot_out_q;
    cnt_d      = cnt_q;
    dat_d      = dat_q;
    to_d       = 1'b0;

    // Config port is live in every state; a slot being presented keeps its
    // captured copy in dat_q, so rewrites only show at the next LOAD.
    if (bus.CFG_WE_I)      mask_d[bus.CFG_ADR_I] = bus.CFG_DAT_I;
    if (bus.CFG_LAST_WE_I) last_d                = bus.CFG_ADR_I;

    unique case (state_q)
      S_IDLE: begin
        if (bus.EN_I) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_STROBE;
      end
      S_STROBE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Acknowledge takes priority over a coincident dwell expiry.
        if (bus.ACK_I) begin
          state_d = S_ADVANCE;
        end else if (cnt_q == DWELL_M1) begin
          to_d    = 1'b1;
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        // >= rather than == so a LAST shrunk below the pointer still wraps.
        slot_d  = (slot_q >= last_q) ? '0 : slot_q + 1'b1;
        state_d = bus.EN_I ? S_LOAD : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the upcoming state, so data appears on
    // entry to LOAD (one cycle ahead of the strobe) and the strobe lines up
    // exactly with the STROBE state.
    stb_d  = (state_d == S_STROBE);
    busy_d = (state_d != S_IDLE);
    if (state_d == S_LOAD) begin
      dat_d      = mask_q[slot_d];
      slot_out_d = slot_d;
    end
  end

  // State, mask table and output registers; async reset aborts any slot.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= S_IDLE;
      // NOTE: the mask table has a defined power-up content, so it is reset
      // here with the rest of the state rather than left as plain RAM.
      for (int i = 0; i < NUM_SLOTS; i++) mask_q[i] <= 8'h00;
      last_q     <= LAST_RST;
      slot_q     <= '0;
      slot_out_q <= '0;
      cnt_q      <= '0;
      dat_q      <= 8'h00;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q    <= state_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      slot_q     <= slot_d;
      slot_out_q <= slot_out_d;
      cnt_q      <= cnt_d;
      dat_q      <= dat_d;
      stb_q      <= stb_d;
      busy_q     <= busy_d;
      to_q       <= to_d;
    end
  end

  assign bus.STB_O     = stb_q;
  assign bus.DAT_O     = dat_q;
  assign bus.SLOT_O    = slot_out_q;
  assign bus.BUSY_O    = busy_q;
  assign bus.TIMEOUT_O = to_q;

endmodule

// File: tb/tb_prewish_mask_sequencer.sv
// Bench for prewish_mask_sequencer: table of playout vectors, hand-written
// corner sequences, then random ack timing against a slot-level model.
module tb_prewish_mask_sequencer;

  localparam int NUM_SLOTS = 4;
  localparam int AW        = 2;
  localparam int DWELL     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prewish_mask_sequencer_if #(.AW(AW)) bus ();

  prewish_mask_sequencer #(
    .NUM_SLOTS(NUM_SLOTS),
    .DWELL_W  (16),
    .DWELL    (16'd8)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Slot-level model: a strobe is followed by DWELL wait cycles. An ack in
  // one of those cycles (d = 1..DWELL) gives the next strobe d+3 cycles after
  // the current one; otherwise the timeout pulse lands at DWELL+1 and the
  // next strobe at DWELL+3. d = 0 means no ack at all.
  function automatic int exp_gap(input int d);
    return (d >= 1 && d <= DWELL) ? d + 3 : DWELL + 3;
  endfunction

  function automatic int exp_to(input int d);
    return (d >= 1 && d <= DWELL) ? -1 : DWELL + 1;
  endfunction

  // Observations of the most recent wait_next_strobe call.
  int r_gap, r_to_cycle, r_to_count, r_dat, r_pre_dat, r_slot;

  // Called at the negedge of a cycle `elapsed` cycles after the last strobe;
  // drives ACK_I for one cycle at offset d and waits (bounded) for the next
  // strobe, recording its offset, data, slot and any timeout pulses.
  task automatic wait_next_strobe(input int elapsed, input int d);
    int prev;
    r_gap = -1; r_to_cycle = -1; r_to_count = 0;
    r_dat = -1; r_pre_dat = -1; r_slot = -1;
    prev = int'(bus.DAT_O);
    for (int k = elapsed + 1; k <= elapsed + 30; k++) begin
      @(negedge clk);
      if (bus.TIMEOUT_O) begin
        r_to_count++;
        if (r_to_cycle < 0) r_to_cycle = k;
      end
      if (bus.STB_O) begin
        r_gap     = k;
        r_dat     = int'(bus.DAT_O);
        r_slot    = int'(bus.SLOT_O);
        r_pre_dat = prev;
        break;
      end
      prev       = int'(bus.DAT_O);
      bus.ACK_I  = (k == d);
    end
    bus.ACK_I = 1'b0;
  endtask

  task automatic check_slot(input string tag, input int e_gap, input int e_to,
                            input int e_dat, input int e_slot);
    check({tag, "_gap"},      r_gap,      e_gap);
    check({tag, "_to_cycle"}, r_to_cycle, e_to);
    check({tag, "_to_count"}, r_to_count, (e_to < 0) ? 0 : 1);
    check({tag, "_dat"},      r_dat,      e_dat);
    check({tag, "_pre_dat"},  r_pre_dat,  e_dat);
    check({tag, "_slot"},     r_slot,     e_slot);
  endtask

  task automatic cfg(input logic we, input logic lwe, input int adr, input int dat);
    bus.CFG_WE_I      = we;
    bus.CFG_LAST_WE_I = lwe;
    bus.CFG_ADR_I     = AW'(adr);
    bus.CFG_DAT_I     = 8'(dat);
    @(negedge clk);
    bus.CFG_WE_I      = 1'b0;
    bus.CFG_LAST_WE_I = 1'b0;
  endtask

  typedef struct {
    int d;        // ack offset for the slot currently presented
    int exp_dat;  // mask expected on the following strobe
    int exp_slot; // slot expected on the following strobe
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tbl [NUM_SLOTS];
    int last, ptr, d, stb_seen;

    // Ack-driven playout, then timeout and ack/expiry corner cases.
    vecs[0] = '{5, 'h0F, 1};
    vecs[1] = '{5, 'h55, 2};
    vecs[2] = '{5, 'hFF, 3};
    vecs[3] = '{5, 'hA0, 0};
    vecs[4] = '{0, 'h0F, 1};  // no ack: timeout
    vecs[5] = '{8, 'h55, 2};  // ack coincident with last dwell cycle
    vecs[6] = '{9, 'hFF, 3};  // ack during ADVANCE is ignored
    vecs[7] = '{1, 'hA0, 0};
    vecs[8] = '{3, 'h0F, 1};

    bus.EN_I = 1'b1; bus.CFG_WE_I = 1'b0; bus.CFG_LAST_WE_I = 1'b0;
    bus.CFG_ADR_I = '0; bus.CFG_DAT_I = '0; bus.ACK_I = 1'b0;

    // Reset held with EN_I high.
    repeat (3) @(negedge clk);
    check("rst_stb",  int'(bus.STB_O),     0);
    check("rst_dat",  int'(bus.DAT_O),     0);
    check("rst_busy", int'(bus.BUSY_O),    0);
    check("rst_slot", int'(bus.SLOT_O),    0);
    check("rst_to",   int'(bus.TIMEOUT_O), 0);

    bus.EN_I = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    cfg(1'b1, 1'b0, 0, 'hA0);
    cfg(1'b1, 1'b0, 1, 'h0F);
    cfg(1'b1, 1'b0, 2, 'h55);
    cfg(1'b1, 1'b1, 3, 'hFF);  // slot 3 and LAST=3 in one cycle
    check("idle_busy", int'(bus.BUSY_O), 0);

    bus.EN_I = 1'b1;
    wait_next_strobe(0, 0);
    check_slot("start", 2, -1, 'hA0, 0);

    for (int i = 0; i < 9; i++) begin
      wait_next_strobe(0, vecs[i].d);
      check_slot($sformatf("vec%0d", i), exp_gap(vecs[i].d), exp_to(vecs[i].d),
                 vecs[i].exp_dat, vecs[i].exp_slot);
    end

    // Live rewrite of slot 1 while it is in WAIT.
    @(negedge clk);
    cfg(1'b1, 1'b0, 1, 'h3C);
    check("rewrite_hold_a", int'(bus.DAT_O), 'h0F);
    @(negedge clk);
    check("rewrite_hold_b", int'(bus.DAT_O), 'h0F);
    wait_next_strobe(3, 5);
    check_slot("after_rewrite", exp_gap(5), -1, 'h55, 2);

    // Enable dropped during WAIT of slot 2.
    @(negedge clk);
    bus.EN_I = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.ACK_I = 1'b1;
    @(negedge clk);
    bus.ACK_I = 1'b0;
    check("drop_busy_adv", int'(bus.BUSY_O), 1);
    @(negedge clk);
    check("drop_busy_idle", int'(bus.BUSY_O), 0);
    stb_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.STB_O) stb_seen++;
    end
    check("drop_no_stb", stb_seen, 0);
    bus.EN_I = 1'b1;
    wait_next_strobe(0, 0);
    check_slot("resume", 2, -1, 'hFF, 3);

    // LAST shrunk to 1 while slot 3 is presented.
    @(negedge clk);
    cfg(1'b0, 1'b1, 1, 0);
    wait_next_strobe(2, 4);
    check_slot("shrink", exp_gap(4), -1, 'hA0, 0);
    for (int i = 0; i < 3; i++) begin
      wait_next_strobe(0, 2);
      check_slot($sformatf("short%0d", i), exp_gap(2), -1,
                 (i % 2 == 0) ? 'h3C : 'hA0, (i % 2 == 0) ? 1 : 0);
    end

    // Asynchronous reset in WAIT of slot 1.
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", int'(bus.BUSY_O), 0);
    check("async_dat",  int'(bus.DAT_O),  0);
    check("async_slot", int'(bus.SLOT_O), 0);
    check("async_stb",  int'(bus.STB_O),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("release_stb", int'(bus.STB_O), 0);
    wait_next_strobe(0, 0);
    check_slot("post_reset", 2, -1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      wait_next_strobe(0, 1);
      check_slot($sformatf("post_reset%0d", i), exp_gap(1), -1, 0, i % NUM_SLOTS);
    end

    // Random table, LAST and ack timing against the slot-level model.
    bus.EN_I = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    last = int'($urandom_range(0, NUM_SLOTS - 1));
    for (int i = 0; i < NUM_SLOTS; i++) begin
      tbl[i] = int'($urandom_range(0, 255));
      cfg(1'b1, 1'b0, i, tbl[i]);
    end
    cfg(1'b0, 1'b1, last, 0);
    bus.EN_I = 1'b1;
    ptr = 0;
    wait_next_strobe(0, 0);
    check_slot("rnd_start", 2, -1, tbl[0], 0);
    for (int n = 0; n < 40; n++) begin
      d   = int'($urandom_range(0, 10));
      ptr = (ptr >= last) ? 0 : ptr + 1;
      wait_next_strobe(0, d);
      check_slot($sformatf("rnd%0d_d%0d", n, d), exp_gap(d), exp_to(d), tbl[ptr], ptr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
